// File: rtl/gate_truth_table_checker.sv
// Gate truth-table checker.
// Sweeps every input combination of an N_IN-input gate, holds each vector for
// SETTLE_CYCLES clocks, samples the gate output once, and compares it against
// the selected logic function. Reports a mismatch count, the first failing
// vector, and a pass flag at the end of each sweep.
module gate_truth_table_checker #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  output logic [N_IN-1:0]   gate_in,
  input  logic              gate_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid
);

  // Settle counter must hold SETTLE_CYCLES-1; keep at least one bit so that
  // SETTLE_CYCLES == 1 still yields a legal vector.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] ALL_ONES = '1;
  localparam logic [N_IN:0]   ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_t;

  state_t         state;
  logic [CW-1:0]  settle_cnt;
  op_t            op_q;
  logic           expected;
  logic           mismatch;
  logic [N_IN:0]  err_next;

  // Reference function of the latched op applied to the current vector.
  always_comb begin
    // NOTE: assign a default before the case so every path drives the
    // signal; otherwise synthesis infers a latch to hold the old value.
    expected = 1'b0;
    case (op_q)
      OP_AND:  expected = &gate_in;
      OP_OR:   expected = |gate_in;
      OP_NAND: expected = ~&gate_in;
      OP_NOR:  expected = ~|gate_in;
      OP_XOR:  expected = ^gate_in;
      OP_XNOR: expected = ~^gate_in;
      OP_NOT:  expected = ~gate_in[0];
      OP_BUF:  expected = gate_in[0];
      default: expected = 1'b0;
    endcase
  end

  // Compare only in SAMPLE; the counter saturates rather than wrapping.
  always_comb begin
    mismatch = (state == SAMPLE) && (gate_y != expected);
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + 1'b1;
    end
  end

  // Sweep sequencer with registered stimulus and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      op_q             <= OP_AND;
      gate_in          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q             <= op_t'(op);
            gate_in          <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            settle_cnt       <= CNT_LOAD;
            busy             <= 1'b1;
            state            <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= gate_in;
            first_fail_valid <= 1'b1;
          end
          if (gate_in == ALL_ONES) begin
            // pass reflects the count including this last sample.
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= DONE;
          end else begin
            gate_in    <= gate_in + 1'b1;
            settle_cnt <= CNT_LOAD;
            state      <= SETTLE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
